// File: rtl/sampler_job_arbiter_if.sv
// Bundles the two requester ports, the shared sampler port and the result stream.
// master: the arbiter; slave: the surrounding requesters, sampler and result sink.
interface sampler_job_arbiter_if #(
    parameter int INPUT_COUNT  = 784,
    parameter int OUTPUT_COUNT = 256,
    parameter int DATA_WIDTH   = 16
);
    logic                                 req_real;
    logic                                 req_gen;
    logic [DATA_WIDTH*INPUT_COUNT-1:0]    frame_real;
    logic [DATA_WIDTH*INPUT_COUNT-1:0]    frame_gen;
    logic                                 grant_real;
    logic                                 grant_gen;

    logic                                 smp_start;
    logic [DATA_WIDTH*INPUT_COUNT-1:0]    smp_frame;
    logic                                 smp_done;
    logic [DATA_WIDTH*OUTPUT_COUNT-1:0]   smp_sampled;

    logic                                 out_valid;
    logic                                 out_ready;
    logic [DATA_WIDTH*OUTPUT_COUNT-1:0]   out_data;
    logic                                 out_src;

    logic                                 busy;
    logic                                 timeout_err;

    modport master (
        input  req_real, req_gen, frame_real, frame_gen,
        output grant_real, grant_gen,
        output smp_start, smp_frame,
        input  smp_done, smp_sampled,
        output out_valid, out_data, out_src,
        input  out_ready,
        output busy, timeout_err
    );

    modport slave (
        output req_real, req_gen, frame_real, frame_gen,
        input  grant_real, grant_gen,
        input  smp_start, smp_frame,
        output smp_done, smp_sampled,
        input  out_valid, out_data, out_src,
        output out_ready,
        input  busy, timeout_err
    );
endinterface

// File: rtl/sampler_job_arbiter.sv
// Round-robin arbiter sharing one frame sampler between the real and generator paths.
// Define SAMPLER_ARB_TIMEOUT_EN to compile in the WAIT-state watchdog (timeout_err).
module sampler_job_arbiter #(
    parameter int INPUT_COUNT    = 784,
    parameter int OUTPUT_COUNT   = 256,
    parameter int DATA_WIDTH     = 16,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    sampler_job_arbiter_if.master bus
);
    localparam int FRAME_W  = DATA_WIDTH * INPUT_COUNT;
    localparam int RESULT_W = DATA_WIDTH * OUTPUT_COUNT;

    typedef enum logic [1:0] {ST_IDLE, ST_LAUNCH, ST_WAIT, ST_HOLD} state_t;

    state_t                state_q, state_d;
    logic                  armed_q, armed_d;
    logic                  last_gen_q, last_gen_d;
    logic                  grant_real_q, grant_real_d;
    logic                  grant_gen_q, grant_gen_d;
    logic                  smp_start_q, smp_start_d;
    logic [FRAME_W-1:0]    smp_frame_q, smp_frame_d;
    logic                  out_valid_q, out_valid_d;
    logic [RESULT_W-1:0]   out_data_q, out_data_d;
    logic                  out_src_q, out_src_d;
    logic                  busy_q, busy_d;
    logic                  pick_gen;

`ifdef SAMPLER_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  timeout_err_q, timeout_err_d;
`endif

    always_comb begin
        state_d      = state_q;
        armed_d      = 1'b1;
        last_gen_d   = last_gen_q;
        grant_real_d = 1'b0;
        grant_gen_d  = 1'b0;
        smp_start_d  = 1'b0;
        smp_frame_d  = smp_frame_q;
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        out_src_d    = out_src_q;
        pick_gen     = 1'b0;
`ifdef SAMPLER_ARB_TIMEOUT_EN
        cnt_d         = cnt_q;
        timeout_err_d = 1'b0;
`endif

        case (state_q)
            ST_IDLE: begin
                // armed_q holds off arbitration for the first edge after reset release
                if (armed_q && (bus.req_real || bus.req_gen)) begin
                    pick_gen     = bus.req_gen && (!bus.req_real || !last_gen_q);
                    smp_frame_d  = pick_gen ? bus.frame_gen : bus.frame_real;
                    grant_real_d = !pick_gen;
                    grant_gen_d  = pick_gen;
                    out_src_d    = pick_gen;
                    state_d      = ST_LAUNCH;
                end
            end
            ST_LAUNCH: begin
                smp_start_d = 1'b1;
                state_d     = ST_WAIT;
`ifdef SAMPLER_ARB_TIMEOUT_EN
                cnt_d       = '0;
`endif
            end
            ST_WAIT: begin
                if (bus.smp_done) begin
                    out_data_d  = bus.smp_sampled;
                    out_valid_d = 1'b1;
                    state_d     = ST_HOLD;
                end
`ifdef SAMPLER_ARB_TIMEOUT_EN
                else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    timeout_err_d = 1'b1;
                    last_gen_d    = out_src_q;
                    state_d       = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            ST_HOLD: begin
                if (out_ready_hs()) begin
                    out_valid_d = 1'b0;
                    last_gen_d  = out_src_q;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    function automatic logic out_ready_hs();
        return out_valid_q && bus.out_ready;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            armed_q      <= 1'b0;
            last_gen_q   <= 1'b1;
            grant_real_q <= 1'b0;
            grant_gen_q  <= 1'b0;
            smp_start_q  <= 1'b0;
            smp_frame_q  <= '0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_src_q    <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            armed_q      <= armed_d;
            last_gen_q   <= last_gen_d;
            grant_real_q <= grant_real_d;
            grant_gen_q  <= grant_gen_d;
            smp_start_q  <= smp_start_d;
            smp_frame_q  <= smp_frame_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_src_q    <= out_src_d;
            busy_q       <= busy_d;
        end
    end

`ifdef SAMPLER_ARB_TIMEOUT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q         <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            cnt_q         <= cnt_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign bus.timeout_err = timeout_err_q;
`else
    // Watchdog compiled out: evaluates to 0 for every legal TIMEOUT_CYCLES
    assign bus.timeout_err = (TIMEOUT_CYCLES < 0);
`endif

    assign bus.grant_real = grant_real_q;
    assign bus.grant_gen  = grant_gen_q;
    assign bus.smp_start  = smp_start_q;
    assign bus.smp_frame  = smp_frame_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_data   = out_data_q;
    assign bus.out_src    = out_src_q;
    assign bus.busy       = busy_q;
endmodule

// File: tb/tb_sampler_job_arbiter.sv
// Directed bench for sampler_job_arbiter: vector table plus multi-cycle corner sequences.
// The sampler model keeps every even-indexed sample and answers four cycles after smp_start.
module tb_sampler_job_arbiter;
    localparam int IC = 8;
    localparam int OC = 4;
    localparam int DW = 8;
    localparam int TO = 16;

    localparam logic [63:0] F_A = 64'h0706050403020100;
    localparam logic [63:0] F_B = 64'h1716151413121110;
    localparam logic [63:0] F_C = 64'hF0E0D0C0B0A09080;
    localparam logic [63:0] F_D = 64'h0123456789ABCDEF;
    localparam logic [31:0] R_A = 32'h06040200;
    localparam logic [31:0] R_B = 32'h16141210;
    localparam logic [31:0] R_C = 32'hE0C0A080;
    localparam logic [31:0] R_D = 32'h2367ABEF;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sampler_job_arbiter_if #(.INPUT_COUNT(IC), .OUTPUT_COUNT(OC), .DATA_WIDTH(DW)) bus ();

    sampler_job_arbiter #(
        .INPUT_COUNT(IC), .OUTPUT_COUNT(OC), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        rr;
        logic        rg;
        logic [63:0] fr;
        logic [63:0] fg;
        logic        src;
        logic [31:0] data;
    } vec_t;
    vec_t vecs[6];

    // Sampler model
    logic        model_en    = 1'b1;
    logic        manual_done = 1'b0;
    logic [31:0] manual_data = '0;
    int          model_cd    = 0;
    logic [31:0] model_res   = '0;

    function automatic logic [31:0] decim(input logic [63:0] f);
        logic [31:0] r;
        for (int k = 0; k < 4; k++) r[8*k +: 8] = f[16*k +: 8];
        return r;
    endfunction

    initial begin
        logic fire;
        bus.smp_done    = 1'b0;
        bus.smp_sampled = '0;
        forever begin
            @(posedge clk);
            #2;
            fire = 1'b0;
            if (model_cd > 0) begin
                model_cd--;
                if (model_cd == 0) fire = 1'b1;
            end
            if (bus.smp_start === 1'b1 && model_en) begin
                model_cd  = 4;
                model_res = decim(bus.smp_frame);
            end
            bus.smp_done    = fire | manual_done;
            bus.smp_sampled = manual_done ? manual_data : model_res;
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_grant(input string nm);
        int n = 0;
        while (bus.grant_real !== 1'b1 && bus.grant_gen !== 1'b1 && n < 40) begin
            step();
            n++;
        end
        chk({nm, "_grant_seen"}, 64'(bus.grant_real | bus.grant_gen), 64'd1);
    endtask

    task automatic wait_valid(input string nm);
        int n = 0;
        while (bus.out_valid !== 1'b1 && n < 40) begin
            step();
            n++;
        end
        chk({nm, "_valid_seen"}, 64'(bus.out_valid), 64'd1);
    endtask

    task automatic check_reset_outputs(input string nm);
        chk({nm, "_grant_real"},  64'(bus.grant_real),  64'd0);
        chk({nm, "_grant_gen"},   64'(bus.grant_gen),   64'd0);
        chk({nm, "_smp_start"},   64'(bus.smp_start),   64'd0);
        chk({nm, "_out_valid"},   64'(bus.out_valid),   64'd0);
        chk({nm, "_busy"},        64'(bus.busy),        64'd0);
        chk({nm, "_out_src"},     64'(bus.out_src),     64'd0);
        chk({nm, "_timeout_err"}, 64'(bus.timeout_err), 64'd0);
        chk({nm, "_smp_frame"},   bus.smp_frame,        64'd0);
        chk({nm, "_out_data"},    64'(bus.out_data),    64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "bench did not finish");
    end

    initial begin
        logic [1:0] exp_src_seq;
        vecs[0] = '{rr: 1'b1, rg: 1'b0, fr: F_A, fg: F_B, src: 1'b0, data: R_A};
        vecs[1] = '{rr: 1'b0, rg: 1'b1, fr: F_A, fg: F_B, src: 1'b1, data: R_B};
        vecs[2] = '{rr: 1'b1, rg: 1'b1, fr: F_C, fg: F_D, src: 1'b0, data: R_C};
        vecs[3] = '{rr: 1'b1, rg: 1'b1, fr: F_C, fg: F_D, src: 1'b1, data: R_D};
        vecs[4] = '{rr: 1'b0, rg: 1'b1, fr: F_C, fg: F_D, src: 1'b1, data: R_D};
        vecs[5] = '{rr: 1'b1, rg: 1'b1, fr: F_A, fg: F_B, src: 1'b0, data: R_A};

        // Both requests held high across reset
        bus.req_real   = 1'b1;
        bus.req_gen    = 1'b1;
        bus.frame_real = F_A;
        bus.frame_gen  = F_B;
        bus.out_ready  = 1'b1;
        repeat (3) step();
        check_reset_outputs("reset");
        rst = 1'b0;
        step();
        chk("first_edge_no_grant", 64'(bus.grant_real | bus.grant_gen), 64'd0);

        exp_src_seq = 2'b10;
        for (int j = 0; j < 3; j++) begin
            logic es;
            es = (j == 1);
            wait_grant($sformatf("tie%0d", j));
            chk($sformatf("tie%0d_grant_gen", j), 64'(bus.grant_gen), 64'(es));
            chk($sformatf("tie%0d_grant_real", j), 64'(bus.grant_real), 64'(!es));
            if (j == 2) begin
                bus.req_real = 1'b0;
                bus.req_gen  = 1'b0;
            end
            step();
            chk($sformatf("tie%0d_smp_start", j), 64'(bus.smp_start), 64'd1);
            wait_valid($sformatf("tie%0d", j));
            chk($sformatf("tie%0d_out_src", j), 64'(bus.out_src), 64'(es));
            chk($sformatf("tie%0d_out_data", j), 64'(bus.out_data), 64'(es ? R_B : R_A));
            $display("job tie%0d src=%0d data=%h", j, bus.out_src, bus.out_data);
            step();
        end

        // Table-driven jobs
        for (int i = 0; i < 6; i++) begin
            bus.frame_real = vecs[i].fr;
            bus.frame_gen  = vecs[i].fg;
            bus.req_real   = vecs[i].rr;
            bus.req_gen    = vecs[i].rg;
            wait_grant($sformatf("v%0d", i));
            chk($sformatf("v%0d_grant_gen", i), 64'(bus.grant_gen), 64'(vecs[i].src));
            chk($sformatf("v%0d_grant_real", i), 64'(bus.grant_real), 64'(!vecs[i].src));
            chk($sformatf("v%0d_smp_frame", i), bus.smp_frame,
                vecs[i].src ? vecs[i].fg : vecs[i].fr);
            bus.req_real = 1'b0;
            bus.req_gen  = 1'b0;
            wait_valid($sformatf("v%0d", i));
            chk($sformatf("v%0d_out_data", i), 64'(bus.out_data), 64'(vecs[i].data));
            chk($sformatf("v%0d_out_src", i), 64'(bus.out_src), 64'(vecs[i].src));
            $display("job v%0d src=%0d data=%h", i, bus.out_src, bus.out_data);
            step();
            chk($sformatf("v%0d_idle_busy", i), 64'(bus.busy), 64'd0);
        end

        // HOLD stall with a generator request waiting behind it
        bus.out_ready  = 1'b0;
        bus.frame_real = F_C;
        bus.req_real   = 1'b1;
        wait_grant("stall");
        chk("stall_grant_real", 64'(bus.grant_real), 64'd1);
        bus.req_real = 1'b0;
        wait_valid("stall");
        bus.frame_gen = F_D;
        bus.req_gen   = 1'b1;
        for (int c = 0; c < 10; c++) begin
            step();
            chk($sformatf("stall%0d_valid", c), 64'(bus.out_valid), 64'd1);
            chk($sformatf("stall%0d_data", c), 64'(bus.out_data), 64'(R_C));
            chk($sformatf("stall%0d_grant", c), 64'(bus.grant_real | bus.grant_gen), 64'd0);
        end
        bus.out_ready = 1'b1;
        step();
        chk("stall_hs_valid", 64'(bus.out_valid), 64'd0);
        chk("stall_turnaround_grant", 64'(bus.grant_gen), 64'd0);
        step();
        chk("stall_pending_gen_grant", 64'(bus.grant_gen), 64'd1);
        bus.req_gen = 1'b0;
        $display("job stall src=0 data=%h", R_C);
        // A real request raised and dropped while busy must leave no trace
        step();
        bus.req_real = 1'b1;
        step();
        step();
        bus.req_real = 1'b0;
        wait_valid("pend");
        chk("pend_out_data", 64'(bus.out_data), 64'(R_D));
        chk("pend_out_src", 64'(bus.out_src), 64'd1);
        $display("job pend src=%0d data=%h", bus.out_src, bus.out_data);
        step();
        for (int c = 0; c < 5; c++) begin
            step();
            chk($sformatf("withdrawn%0d_grant", c), 64'(bus.grant_real | bus.grant_gen), 64'd0);
            chk($sformatf("withdrawn%0d_busy", c), 64'(bus.busy), 64'd0);
        end

        // Frame changed right after its grant
        bus.frame_real = F_A;
        bus.req_real   = 1'b1;
        wait_grant("fchg");
        chk("fchg_grant_real", 64'(bus.grant_real), 64'd1);
        bus.frame_real = F_D;
        bus.req_real   = 1'b0;
        step();
        chk("fchg_smp_frame", bus.smp_frame, F_A);
        wait_valid("fchg");
        chk("fchg_smp_frame_hold", bus.smp_frame, F_A);
        chk("fchg_out_data", 64'(bus.out_data), 64'(R_A));
        $display("job fchg src=%0d data=%h", bus.out_src, bus.out_data);
        step();

        // Reset during WAIT, late smp_done must be ignored
        model_en      = 1'b0;
        bus.frame_gen = F_B;
        bus.req_gen   = 1'b1;
        wait_grant("rstw");
        chk("rstw_grant_gen", 64'(bus.grant_gen), 64'd1);
        bus.req_gen = 1'b0;
        step();
        step();
        step();
        chk("rstw_busy_before", 64'(bus.busy), 64'd1);
        rst = 1'b1;
        #1;
        check_reset_outputs("rstw");
        @(posedge clk);
        #1;
        rst = 1'b0;
        step();
        step();
        manual_done = 1'b1;
        manual_data = 32'hDEADBEEF;
        step();
        manual_done = 1'b0;
        for (int c = 0; c < 5; c++) begin
            step();
            chk($sformatf("rstw%0d_out_valid", c), 64'(bus.out_valid), 64'd0);
            chk($sformatf("rstw%0d_busy", c), 64'(bus.busy), 64'd0);
        end
        $display("job rstw abandoned");

        // WAIT with no smp_done
        bus.frame_real = F_A;
        bus.frame_gen  = F_B;
        bus.req_real   = 1'b1;
        bus.req_gen    = 1'b1;
        wait_grant("wdog");
        chk("wdog_grant_real", 64'(bus.grant_real), 64'd1);
        bus.req_real = 1'b0;
        step();
        chk("wdog_smp_start", 64'(bus.smp_start), 64'd1);
`ifdef SAMPLER_ARB_TIMEOUT_EN
        for (int k = 1; k <= TO; k++) begin
            step();
            if (k < TO) chk($sformatf("wdog%0d_quiet", k), 64'(bus.timeout_err), 64'd0);
        end
        chk("wdog_timeout_pulse", 64'(bus.timeout_err), 64'd1);
        chk("wdog_out_valid", 64'(bus.out_valid), 64'd0);
        chk("wdog_busy", 64'(bus.busy), 64'd0);
        model_en = 1'b1;
        step();
        chk("wdog_pulse_end", 64'(bus.timeout_err), 64'd0);
        chk("wdog_next_grant_gen", 64'(bus.grant_gen), 64'd1);
        bus.req_gen = 1'b0;
        wait_valid("wdog_gen");
        chk("wdog_gen_data", 64'(bus.out_data), 64'(R_B));
        $display("job wdog_gen src=%0d data=%h", bus.out_src, bus.out_data);
        step();
`else
        for (int k = 0; k < 40; k++) begin
            step();
            chk($sformatf("wait%0d_busy", k), 64'(bus.busy), 64'd1);
            chk($sformatf("wait%0d_timeout_err", k), 64'(bus.timeout_err), 64'd0);
        end
        $display("job wait held busy");
        bus.req_gen = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        model_en = 1'b1;
        step();
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
